period_meter: RTL and testbench
===============================

# period_meter

Measures the period and high time of a slow, asynchronous square wave, such as a divided clock or a blinking status line, in cycles of the system clock. It reports each completed measurement through a valid/ready result interface, and flags overruns and missing-signal timeouts. It sits on the consuming side of divided-clock generation and is used for on-chip self-check of generated slow clocks and for external frequency readout.

## Interface
- W, 32: width of counters and result fields.
- TIMEOUT, 100000000: clk cycles without a rising edge before timeout is declared; must be ≥ 2 and < 2^W.
- clk  input  1  system clock; all logic is on its rising edge.
- rst  input  1  reset; asynchronous, active-low (asserted when 0).
- sig_in  input  1  measured signal; asynchronous to clk.
- meas_en  input  1  measurement enable; level-sensitive.
- period  output  W  clk cycles between two consecutive rising edges of sig_in.
- high_time  output  W  clk cycles from a rising edge to the following falling edge.
- valid  output  1  result held on period/high_time.
- ready  input  1  consumer accepts the result when valid && ready.
- overrun  output  1  sticky; a result was dropped because the previous one was not accepted.
- timeout  output  1  sticky; no rising edge for TIMEOUT cycles while armed or measuring.
- clr_flags  input  1  one-cycle pulse; clears overrun and timeout.

## Operation
- Input path: a 2-flop synchronizer, then an edge register. rise_det = s & ~s_d and fall_det = ~s & s_d; each is a single-cycle pulse.
- State machine with three states: IDLE, ARM, MEAS.
  - IDLE: cnt and hcnt are held at 0. Go to ARM when meas_en = 1.
  - ARM: wait for rise_det. On rise_det: cnt <= 1, hcnt_run <= 1, go to MEAS.
  - MEAS: cnt increments every cycle.
    - hcnt increments while hcnt_run = 1.
    - fall_det clears hcnt_run, which freezes hcnt.
    - On rise_det, a result is produced: cnt → period and hcnt → high_time. Then cnt <= 1, hcnt <= 0, hcnt_run <= 1, and the state stays MEAS, so back-to-back periods are measured with no gap.
- Counting rule: if rise_det fires at cycles t0 and t1, then period = t1 − t0. Likewise high_time = tf − t0, where tf is the cycle of fall_det.
- Timeout:
  - In ARM or MEAS, a separate idle counter counts cycles since the last rise_det (or since entering ARM).
  - When it reaches TIMEOUT − 1: timeout <= 1, go to ARM, and no result is produced.
  - cnt never wraps, because TIMEOUT < 2^W.
- meas_en = 0 in any state: go to IDLE at the next clock and discard the partial measurement. A held result and its valid are unaffected.
- Result handshake:
  - A new result loads period/high_time and sets valid = 1.
  - valid && ready clears valid in the next cycle, unless a new result arrives in that same cycle.
  - If a new result arrives while valid = 1 and ready = 0: the new result is dropped, the old result is kept, and overrun <= 1.
  - If a new result arrives while valid = 1 and ready = 1: the new result is loaded, valid stays 1, and overrun is unchanged.
- clr_flags clears both overrun and timeout. If clr_flags coincides with a new overrun or timeout event, the set wins.
- A level or edge of sig_in that occurs while in IDLE is ignored.

## Timing
- Reset values: period = 0, high_time = 0, valid = 0, overrun = 0, timeout = 0. Internally: state = IDLE, synchronizer and edge flops = 0, all counters = 0.
- Reset is asynchronous. Asserting it mid-measurement immediately clears all outputs and state. After reset is released, the first result requires a fresh ARM → first rise → second rise sequence.
- Latency from a sig_in rising edge to rise_det is 2 to 3 clk cycles (synchronizer uncertainty). The latency is identical for every edge, so period is exact for a synchronous sig_in.
- valid rises 1 cycle after the rise_det that completes a period.
- Minimum measurable period is 2 cycles (high 1, low 1 after synchronization). Behaviour for faster inputs is unspecified.
- A result is never produced on the first rise after ARM.

## Test plan
- Basic measurement:
  - Stimulus: meas_en = 1, ready = 1, sig_in synchronous square wave with period 10 and high 4.
  - Response: after the second rising edge, every result is period = 10, high_time = 4. valid pulses once per period. overrun = 0.
- Divided clock:
  - Stimulus: sig_in driven by a toggle-every-2-cycles register; ready = 1.
  - Response: period = 4, high_time = 2 on each result.
- Overrun:
  - Stimulus: ready = 0 and three periods of length 8.
  - Response: the first result is held with valid = 1, and overrun = 1 after the second result. Then ready = 1 for one cycle → valid = 0. Then clr_flags → overrun = 0.
- Timeout:
  - Stimulus: TIMEOUT = 20, one rise, then sig_in held at 1.
  - Response: timeout = 1 exactly 19 cycles after that rise_det, with no valid. A later rising edge rearms, and a result appears after the following rise.
- Enable and reset mid-measurement:
  - Stimulus: drop meas_en halfway through a period, then restore it.
  - Response: no result for the interrupted period, and the next two rises give a correct period.
  - Stimulus: assert rst asynchronously between clock edges while valid = 1.
  - Response: valid, period and the flags are 0 immediately.
- Simultaneous events:
  - Stimulus: valid = 1 with ready = 1 in the same cycle a new result completes.
  - Response: the new values are loaded, valid stays 1, and overrun = 0.

Source files
------------

// File: rtl/period_meter.sv
// period_meter: measures period and high time of a slow asynchronous square wave in clk cycles
module period_meter #(
    parameter int W       = 32,
    parameter int TIMEOUT = 100000000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sig_in,
    input  logic         meas_en,
    output logic [W-1:0] period,
    output logic [W-1:0] high_time,
    output logic         valid,
    input  logic         ready,
    output logic         overrun,
    output logic         timeout,
    input  logic         clr_flags
);
    typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;

    localparam logic [W-1:0] ONE    = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] TO_LIM = W'(TIMEOUT - 1);

    state_t         state_q, state_d;
    logic           s1_q, s2_q, sd_q;
    logic [W-1:0]   cnt_q, cnt_d, hcnt_q, hcnt_d, idle_q, idle_d;
    logic [W-1:0]   period_q, period_d, high_q, high_d;
    logic           hrun_q, hrun_d, valid_q, valid_d, ovr_q, ovr_d, to_q, to_d;
    logic           rise, fall, active, to_hit, res, load;
    logic [W-1:0]   idle_inc;

    assign rise     = s2_q & ~sd_q;
    assign fall     = ~s2_q & sd_q;
    assign active   = meas_en && state_q != IDLE;
    assign idle_inc = idle_q + ONE;
    assign to_hit   = active && !rise && idle_inc >= TO_LIM;
    assign res      = active && state_q == MEAS && rise;
    assign load     = res && (!valid_q || ready);

    assign period    = period_q;
    assign high_time = high_q;
    assign valid     = valid_q;
    assign overrun   = ovr_q;
    assign timeout   = to_q;

    // Next state and counters: a rise restarts the period, the idle counter guards against a dead input
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hcnt_d  = hcnt_q;
        hrun_d  = hrun_q;
        idle_d  = idle_q;
        if (!meas_en) begin
            state_d = IDLE;
            cnt_d   = '0;
            hcnt_d  = '0;
            hrun_d  = 1'b0;
            idle_d  = '0;
        end else if (state_q == IDLE) begin
            state_d = ARM;
        end else if (rise) begin
            state_d = MEAS;
            cnt_d   = ONE;
            hcnt_d  = '0;
            hrun_d  = 1'b1;
            idle_d  = ONE;
        end else if (to_hit) begin
            state_d = ARM;
            cnt_d   = '0;
            hcnt_d  = '0;
            hrun_d  = 1'b0;
            idle_d  = '0;
        end else begin
            idle_d = idle_inc;
            if (state_q == MEAS) begin
                cnt_d  = cnt_q + ONE;
                hcnt_d = hrun_q ? hcnt_q + ONE : hcnt_q;
                hrun_d = hrun_q & ~fall;
            end
        end
    end

    // Result register: a result arriving while the old one is still unaccepted is dropped
    always_comb begin
        period_d = load ? cnt_q : period_q;
        high_d   = load ? hcnt_q : high_q;
        valid_d  = load || (valid_q && !ready);
        ovr_d    = (res && valid_q && !ready) || (ovr_q && !clr_flags);
        to_d     = to_hit || (to_q && !clr_flags);
    end

    // Synchronizer, edge register, FSM, counters and result state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            sd_q     <= 1'b0;
            state_q  <= IDLE;
            cnt_q    <= '0;
            hcnt_q   <= '0;
            hrun_q   <= 1'b0;
            idle_q   <= '0;
            period_q <= '0;
            high_q   <= '0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            s1_q     <= sig_in;
            s2_q     <= s1_q;
            sd_q     <= s2_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hcnt_q   <= hcnt_d;
            hrun_q   <= hrun_d;
            idle_q   <= idle_d;
            period_q <= period_d;
            high_q   <= high_d;
            valid_q  <= valid_d;
            ovr_q    <= ovr_d;
            to_q     <= to_d;
        end
    end
endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: directed and randomized waveform checks of period_meter against a pulse-list model
module tb_period_meter;
    logic        clk = 1'b0, rst = 1'b0, sig_in = 1'b0, meas_en = 1'b0, ready = 1'b0, clr_flags = 1'b0;
    logic [31:0] period, high_time;
    logic        valid, overrun, timeout;
    int          tests = 0, fails = 0, nres = 0, n0 = 0;
    bit          mon_on = 1'b0, have_prev = 1'b0;
    int          prev_h = 0, prev_l = 0;
    int          pq[$], hq[$];

    period_meter #(.W(32), .TIMEOUT(20)) dut (
        .clk(clk), .rst(rst), .sig_in(sig_in), .meas_en(meas_en),
        .period(period), .high_time(high_time), .valid(valid), .ready(ready),
        .overrun(overrun), .timeout(timeout), .clr_flags(clr_flags)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check1(string tag, logic obs, logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One high/low pulse; its rise completes the previous pulse's period
    task automatic pair(int h, int l);
        if (have_prev) begin
            pq.push_back(prev_h + prev_l);
            hq.push_back(prev_h);
        end
        sig_in = 1'b1;
        tick(h);
        sig_in = 1'b0;
        tick(l);
        prev_h    = h;
        prev_l    = l;
        have_prev = 1'b1;
    endtask

    task automatic restart;
        meas_en = 1'b0;
        tick(2);
        meas_en = 1'b1;
        tick(2);
        have_prev = 1'b0;
        pq.delete();
        hq.delete();
    endtask

    task automatic drain(string tag);
        tick(6);
        check(tag, 32'(pq.size()), 0);
    endtask

    always @(negedge clk) begin
        if (mon_on && valid && ready) begin
            nres++;
            if (pq.size() == 0) check1("spurious_result", valid, 1'b0);
            else begin
                check("period", period, pq.pop_front());
                check("high_time", high_time, hq.pop_front());
            end
        end
    end

    initial begin
        tick(2);
        check("rst_period", period, 0);
        check("rst_high", high_time, 0);
        check1("rst_valid", valid, 1'b0);
        check1("rst_overrun", overrun, 1'b0);
        check1("rst_timeout", timeout, 1'b0);
        rst = 1'b1;
        tick(1);

        ready  = 1'b1;
        mon_on = 1'b1;
        restart;
        repeat (5) pair(4, 6);
        drain("basic_drain");
        check("basic_count", nres, 4);
        check1("basic_overrun", overrun, 1'b0);

        n0 = nres;
        restart;
        repeat (6) pair(2, 2);
        drain("div_drain");
        check("div_count", nres, n0 + 5);

        n0 = nres;
        restart;
        repeat (20) pair($urandom_range(1, 8), $urandom_range(1, 8));
        drain("rand_drain");
        check("rand_count", nres, n0 + 19);
        check1("rand_overrun", overrun, 1'b0);

        mon_on = 1'b0;
        ready  = 1'b0;
        restart;
        pair(4, 4);
        pair(4, 4);
        check1("ovr_first_valid", valid, 1'b1);
        check1("ovr_first_flag", overrun, 1'b0);
        check("ovr_first_period", period, 8);
        check("ovr_first_high", high_time, 4);
        pair(4, 4);
        check1("ovr_flag", overrun, 1'b1);
        check1("ovr_held_valid", valid, 1'b1);
        check("ovr_held_period", period, 8);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        check1("ovr_ack_valid", valid, 1'b0);
        clr_flags = 1'b1;
        tick(1);
        clr_flags = 1'b0;
        check1("ovr_cleared", overrun, 1'b0);

        restart;
        clr_flags = 1'b1;
        tick(1);
        clr_flags = 1'b0;
        check1("to_clear", timeout, 1'b0);
        sig_in = 1'b1;
        tick(20);
        check1("to_early", timeout, 1'b0);
        tick(1);
        check1("to_set", timeout, 1'b1);
        check1("to_no_valid", valid, 1'b0);
        sig_in    = 1'b0;
        ready     = 1'b1;
        mon_on    = 1'b1;
        have_prev = 1'b0;
        n0        = nres;
        tick(2);
        pair(5, 5);
        pair(5, 5);
        drain("to_rearm_drain");
        check("to_rearm_count", nres, n0 + 1);

        n0 = nres;
        restart;
        pair(3, 7);
        pq.push_back(10);
        hq.push_back(3);
        sig_in = 1'b1;
        tick(3);
        sig_in = 1'b0;
        tick(2);
        meas_en = 1'b0;
        tick(2);
        meas_en = 1'b1;
        tick(2);
        have_prev = 1'b0;
        repeat (3) pair(3, 7);
        drain("en_drain");
        check("en_count", nres, n0 + 3);

        mon_on = 1'b0;
        ready  = 1'b0;
        restart;
        pair(3, 3);
        pair(3, 3);
        check1("rst_pre_valid", valid, 1'b1);
        check("rst_pre_period", period, 6);
        #3 rst = 1'b0;
        #1;
        check1("arst_valid", valid, 1'b0);
        check("arst_period", period, 0);
        check("arst_high", high_time, 0);
        check1("arst_overrun", overrun, 1'b0);
        check1("arst_timeout", timeout, 1'b0);
        #2 rst = 1'b1;
        tick(1);
        pq.delete();
        hq.delete();
        have_prev = 1'b0;
        ready     = 1'b1;
        mon_on    = 1'b1;
        n0        = nres;
        tick(2);
        repeat (3) pair(3, 3);
        drain("post_rst_drain");
        check("post_rst_count", nres, n0 + 2);

        mon_on = 1'b0;
        ready  = 1'b0;
        restart;
        pair(2, 4);
        pair(3, 5);
        check1("sim_hold_valid", valid, 1'b1);
        check("sim_hold_period", period, 6);
        check("sim_hold_high", high_time, 2);
        sig_in = 1'b1;
        tick(2);
        ready = 1'b1;
        tick(1);
        check("sim_period", period, 8);
        check("sim_high", high_time, 3);
        check1("sim_valid", valid, 1'b1);
        check1("sim_overrun", overrun, 1'b0);
        tick(1);
        check1("sim_ack", valid, 1'b0);
        sig_in = 1'b0;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
